unidade_contexto_processos: RTL and testbench

- Parametrised successor to the single-PID process support in the single-cycle core. It replaces the bare PID_CPU register and external memory offset with a table of NUM_PROC process contexts: valid, saved PC, base and limit.
- Adds a round-robin scheduler driven by a quantum timer, plus yield/exit handling and bounds checking on data accesses.
- Sits beside the core: drives PC reload, stall, PID_CPU and the relocated data address.

---
 rtl/unidade_contexto_processos.sv | 199 +++++++++++++++++++
 tb/tb_unidade_contexto_processos.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_contexto_processos.sv
// Process context table with round-robin, quantum-driven scheduler and bounds-checked data relocation.
// Optional CONTEXT_SWITCH_COUNT_EN adds a saturating context-switch counter on Num_Trocas.
module unidade_contexto_processos #(
    parameter int NUM_PROC  = 8,
    parameter int PID_W     = 5,
    parameter int ADDR_W    = 32,
    parameter int QUANTUM_W = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Enable_Sched,
    input  logic [QUANTUM_W-1:0] Quantum,
    input  logic [ADDR_W-1:0]    PC_Atual,
    input  logic                 Halt,
    input  logic                 Yield,
    input  logic                 Exit,
    input  logic                 Acesso,
    input  logic [ADDR_W-1:0]    Endereco_Dados,
    input  logic                 Load_Wr,
    input  logic [PID_W-1:0]     Load_PID,
    input  logic [ADDR_W-1:0]    Load_PC,
    input  logic [ADDR_W-1:0]    Load_Base,
    input  logic [ADDR_W-1:0]    Load_Limite,
    output logic                 Load_Err,
    output logic                 Stall,
    output logic                 PC_Load,
    output logic [ADDR_W-1:0]    PC_Novo,
    output logic [PID_W-1:0]     PID_CPU,
    output logic [ADDR_W-1:0]    Endereco_Fisico,
    output logic                 Violacao,
    output logic [15:0]          Num_Trocas
);

    localparam int IDX_W = $clog2(NUM_PROC);
    localparam logic [PID_W:0] NUM_PROC_L = (PID_W + 1)'(NUM_PROC);

    typedef enum logic [1:0] {IDLE, SELECT, RESTORE, RUN} state_t;

    state_t                  state_q, state_d;
    logic [NUM_PROC-1:0]     valid_q, valid_d;
    logic [ADDR_W-1:0]       pc_tab_q    [NUM_PROC];
    logic [ADDR_W-1:0]       pc_tab_d    [NUM_PROC];
    logic [ADDR_W-1:0]       base_tab_q  [NUM_PROC];
    logic [ADDR_W-1:0]       base_tab_d  [NUM_PROC];
    logic [ADDR_W-1:0]       limit_tab_q [NUM_PROC];
    logic [ADDR_W-1:0]       limit_tab_d [NUM_PROC];
    logic [PID_W-1:0]        pid_q, pid_d;
    logic [ADDR_W-1:0]       base_q, base_d;
    logic [ADDR_W-1:0]       limit_q, limit_d;
    logic [ADDR_W-1:0]       pc_novo_q, pc_novo_d;
    logic [QUANTUM_W-1:0]    cnt_q, cnt_d;
    logic                    viol_q, viol_d;
    logic                    lerr_q, lerr_d;

    logic [IDX_W-1:0]        cur_idx;
    logic [IDX_W-1:0]        ld_idx;
    logic                    ld_ok;
    logic                    fault;
    logic                    expiry;
    logic                    trigger;
    logic                    rr_found;
    logic [IDX_W-1:0]        rr_sel;
    logic [IDX_W-1:0]        rr_cand;

    assign cur_idx = pid_q[IDX_W-1:0];
    assign ld_idx  = Load_PID[IDX_W-1:0];
    assign ld_ok   = Load_Wr && ({1'b0, Load_PID} < NUM_PROC_L) && !valid_q[ld_idx];

    assign fault   = (state_q == RUN) && Acesso && (Endereco_Dados >= limit_q);
    assign expiry  = Enable_Sched && (Quantum != '0) && (cnt_q == QUANTUM_W'(1)) && !Halt;
    assign trigger = (state_q == RUN) && (Exit || Yield || fault || expiry);

    // Search begins one past the running slot; the index wraps naturally, so the running slot is tried last.
    always_comb begin
        rr_found = 1'b0;
        rr_sel   = '0;
        rr_cand  = '0;
        for (int i = 1; i <= NUM_PROC; i++) begin
            rr_cand = cur_idx + IDX_W'(i);
            if (!rr_found && valid_q[rr_cand]) begin
                rr_found = 1'b1;
                rr_sel   = rr_cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        pc_tab_d    = pc_tab_q;
        base_tab_d  = base_tab_q;
        limit_tab_d = limit_tab_q;
        pid_d       = pid_q;
        base_d      = base_q;
        limit_d     = limit_q;
        pc_novo_d   = pc_novo_q;
        cnt_d       = cnt_q;
        viol_d      = fault;
        lerr_d      = Load_Wr && !ld_ok;

        if (ld_ok) begin
            valid_d[ld_idx]     = 1'b1;
            pc_tab_d[ld_idx]    = Load_PC;
            base_tab_d[ld_idx]  = Load_Base;
            limit_tab_d[ld_idx] = Load_Limite;
        end

        case (state_q)
            IDLE: begin
                if (|valid_q) state_d = SELECT;
            end
            SELECT: begin
                // Context is fetched here so it is already visible while PC_Load is high in RESTORE.
                if (rr_found) begin
                    state_d   = RESTORE;
                    pid_d     = PID_W'(rr_sel);
                    base_d    = base_tab_q[rr_sel];
                    limit_d   = limit_tab_q[rr_sel];
                    pc_novo_d = pc_tab_q[rr_sel];
                end else begin
                    state_d = IDLE;
                end
            end
            RESTORE: begin
                cnt_d   = Quantum;
                state_d = RUN;
            end
            RUN: begin
                if (trigger) begin
                    pc_tab_d[cur_idx] = PC_Atual;
                    state_d           = SELECT;
                    if (Exit || fault) valid_d[cur_idx] = 1'b0;
                end else if (!Halt && (cnt_q > QUANTUM_W'(1))) begin
                    cnt_d = cnt_q - QUANTUM_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            valid_q   <= '0;
            pid_q     <= '0;
            base_q    <= '0;
            limit_q   <= '0;
            pc_novo_q <= '0;
            cnt_q     <= '0;
            viol_q    <= 1'b0;
            lerr_q    <= 1'b0;
            for (int i = 0; i < NUM_PROC; i++) begin
                pc_tab_q[i]    <= '0;
                base_tab_q[i]  <= '0;
                limit_tab_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            pid_q       <= pid_d;
            base_q      <= base_d;
            limit_q     <= limit_d;
            pc_novo_q   <= pc_novo_d;
            cnt_q       <= cnt_d;
            viol_q      <= viol_d;
            lerr_q      <= lerr_d;
            pc_tab_q    <= pc_tab_d;
            base_tab_q  <= base_tab_d;
            limit_tab_q <= limit_tab_d;
        end
    end

    assign Stall           = (state_q != RUN) || trigger;
    assign PC_Load         = (state_q == RESTORE);
    assign PC_Novo         = pc_novo_q;
    assign PID_CPU         = pid_q;
    assign Endereco_Fisico = Endereco_Dados + base_q;
    assign Violacao        = viol_q;
    assign Load_Err        = lerr_q;

`ifdef CONTEXT_SWITCH_COUNT_EN
    logic [15:0] trocas_q, trocas_d;

    always_comb begin
        trocas_d = trocas_q;
        if ((state_q == RESTORE) && (trocas_q != 16'hFFFF)) trocas_d = trocas_q + 16'd1;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) trocas_q <= '0;
        else       trocas_q <= trocas_d;
    end

    assign Num_Trocas = trocas_q;
`else
    assign Num_Trocas = '0;
`endif

endmodule

// File: tb/tb_unidade_contexto_processos.sv
// Directed bench for unidade_contexto_processos: scheduling order, quantum timing, halt, faults, loads, reset.
module tb_unidade_contexto_processos;

    logic        Clock;
    logic        Reset;
    logic        Enable_Sched;
    logic [15:0] Quantum;
    logic [31:0] PC_Atual;
    logic        Halt;
    logic        Yield;
    logic        Exit;
    logic        Acesso;
    logic [31:0] Endereco_Dados;
    logic        Load_Wr;
    logic [4:0]  Load_PID;
    logic [31:0] Load_PC;
    logic [31:0] Load_Base;
    logic [31:0] Load_Limite;
    logic        Load_Err;
    logic        Stall;
    logic        PC_Load;
    logic [31:0] PC_Novo;
    logic [4:0]  PID_CPU;
    logic [31:0] Endereco_Fisico;
    logic        Violacao;
    logic [15:0] Num_Trocas;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_trocas = 0;
    int n;

    unidade_contexto_processos dut (
        .Clock(Clock), .Reset(Reset), .Enable_Sched(Enable_Sched), .Quantum(Quantum),
        .PC_Atual(PC_Atual), .Halt(Halt), .Yield(Yield), .Exit(Exit), .Acesso(Acesso),
        .Endereco_Dados(Endereco_Dados), .Load_Wr(Load_Wr), .Load_PID(Load_PID),
        .Load_PC(Load_PC), .Load_Base(Load_Base), .Load_Limite(Load_Limite),
        .Load_Err(Load_Err), .Stall(Stall), .PC_Load(PC_Load), .PC_Novo(PC_Novo),
        .PID_CPU(PID_CPU), .Endereco_Fisico(Endereco_Fisico), .Violacao(Violacao),
        .Num_Trocas(Num_Trocas)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic load(input logic [4:0] pid, input logic [31:0] pc, input logic [31:0] b,
                        input logic [31:0] l);
        Load_Wr     = 1'b1;
        Load_PID    = pid;
        Load_PC     = pc;
        Load_Base   = b;
        Load_Limite = l;
    endtask

    function automatic logic [31:0] trocas_exp();
`ifdef CONTEXT_SWITCH_COUNT_EN
        return 32'(exp_trocas);
`else
        return 32'd0;
`endif
    endfunction

    // Called in the trigger cycle: walks SELECT, RESTORE and the first RUN cycle.
    task automatic switch_to(input int pid, input logic [31:0] pc, input logic lerr);
        cyc();
        Yield = 1'b0; Exit = 1'b0; Load_Wr = 1'b0; Acesso = 1'b0;
        #1;
        chk("sel_stall", 32'(Stall), 32'd1);
        chk("sel_pc_load", 32'(PC_Load), 32'd0);
        chk("sel_load_err", 32'(Load_Err), 32'(lerr));
        cyc();
        chk("rst_pc_load", 32'(PC_Load), 32'd1);
        chk("rst_pid", 32'(PID_CPU), 32'(pid));
        chk("rst_pc_novo", PC_Novo, pc);
        chk("rst_stall", 32'(Stall), 32'd1);
        cyc();
        exp_trocas++;
        chk("run_stall", 32'(Stall), 32'd0);
        chk("run_pc_load", 32'(PC_Load), 32'd0);
        chk("num_trocas", 32'(Num_Trocas), trocas_exp());
    endtask

    // Index of the first cycle (current cycle = 1) with Stall high, capped at lim.
    task automatic measure(input int lim, output int cnt);
        cnt = 1;
        while (Stall == 1'b0 && cnt < lim) begin
            cyc();
            cnt++;
        end
    endtask

    logic [4:0]  rr_pid   [3] = '{5'd6, 5'd1, 5'd3};
    logic [31:0] rr_pc    [3] = '{32'h6000, 32'h1004, 32'h3008};
    logic [31:0] rr_atual [3] = '{32'h3008, 32'h6008, 32'h1010};

    initial begin
        Reset = 1'b1; Enable_Sched = 1'b1; Quantum = 16'd5; PC_Atual = '0; Halt = 1'b0;
        Yield = 1'b0; Exit = 1'b0; Acesso = 1'b0; Endereco_Dados = '0; Load_Wr = 1'b0;
        Load_PID = '0; Load_PC = '0; Load_Base = '0; Load_Limite = '0;
        #2;
        chk("reset_stall", 32'(Stall), 32'd1);
        chk("reset_pc_load", 32'(PC_Load), 32'd0);
        chk("reset_pc_novo", PC_Novo, 32'd0);
        chk("reset_pid", 32'(PID_CPU), 32'd0);
        chk("reset_violacao", 32'(Violacao), 32'd0);
        chk("reset_load_err", 32'(Load_Err), 32'd0);
        chk("reset_num_trocas", 32'(Num_Trocas), 32'd0);
        cyc(); cyc();
        Reset = 1'b0;

        // Single process: first dispatch, relocation, quantum expiry and reselection.
        load(5'd2, 32'h40, 32'h100, 32'h20);
        cyc();
        Load_Wr = 1'b0;
        #1;
        chk("load2_err", 32'(Load_Err), 32'd0);
        chk("idle_stall", 32'(Stall), 32'd1);
        switch_to(2, 32'h40, 1'b0);
        Acesso = 1'b1; Endereco_Dados = 32'h1F; PC_Atual = 32'h58;
        #1;
        chk("reloc_1f", Endereco_Fisico, 32'h11F);
        chk("inbounds_stall", 32'(Stall), 32'd0);
        Acesso = 1'b0;
        #1;
        measure(50, n);
        chk("quantum5", 32'(n), 32'd5);
        switch_to(2, 32'h58, 1'b0);

        // Three halted cycles must not consume the quantum.
        Halt = 1'b1; PC_Atual = 32'h60;
        cyc(); cyc(); cyc();
        Halt = 1'b0;
        #1;
        chk("halt_no_trigger", 32'(Stall), 32'd0);
        measure(50, n);
        chk("halt_delay", 32'(n), 32'd5);
        switch_to(2, 32'h60, 1'b0);

        // Bounds fault on the only process: Violacao pulse, then IDLE.
        Acesso = 1'b1; Endereco_Dados = 32'h20;
        #1;
        chk("fault_stall", 32'(Stall), 32'd1);
        chk("reloc_20", Endereco_Fisico, 32'h120);
        cyc();
        Acesso = 1'b0;
        chk("violacao_pulse", 32'(Violacao), 32'd1);
        cyc();
        chk("violacao_clear", 32'(Violacao), 32'd0);
        chk("idle_after_fault", 32'(Stall), 32'd1);
        cyc();
        chk("idle_no_pc_load", 32'(PC_Load), 32'd0);
        chk("idle_stall2", 32'(Stall), 32'd1);

        // PID 1 runs with a long quantum while 3 and 6 are loaded.
        Quantum = 16'd100;
        load(5'd1, 32'h1000, 32'h0, 32'hFFFF_FFFF);
        cyc();
        Load_Wr = 1'b0;
        switch_to(1, 32'h1000, 1'b0);
        load(5'd3, 32'h3000, 32'h0, 32'hFFFF_FFFF);
        cyc();
        chk("load3_err", 32'(Load_Err), 32'd0);
        load(5'd6, 32'h6000, 32'h0, 32'hFFFF_FFFF);
        cyc();
        chk("load6_err", 32'(Load_Err), 32'd0);
        load(5'd9, 32'h9000, 32'h0, 32'hFFFF_FFFF);
        cyc();
        chk("load9_range_err", 32'(Load_Err), 32'd1);
        load(5'd3, 32'h3333, 32'h0, 32'hFFFF_FFFF);
        cyc();
        chk("load3_dup_err", 32'(Load_Err), 32'd1);
        Load_Wr = 1'b0;
        cyc();
        chk("load_err_drop", 32'(Load_Err), 32'd0);
        Quantum = 16'd5; PC_Atual = 32'h1004; Yield = 1'b1;
        #1;
        chk("yield_stall", 32'(Stall), 32'd1);
        switch_to(3, 32'h3000, 1'b0);

        // Round robin by quantum: 6, 1, 3.
        for (int k = 0; k < 3; k++) begin
            PC_Atual = rr_atual[k];
            #1;
            measure(50, n);
            chk("rr_quantum", 32'(n), 32'd5);
            switch_to(int'(rr_pid[k]), rr_pc[k], 1'b0);
        end

        // Yield coincident with expiry: exactly one switch (to 6).
        cyc(); cyc(); cyc(); cyc();
        Yield = 1'b1; PC_Atual = 32'h3020;
        #1;
        chk("yield_expiry_stall", 32'(Stall), 32'd1);
        switch_to(6, 32'h6008, 1'b0);

        // Exit of 6 with a same-cycle load of slot 6: load rejected, slot gone.
        Exit = 1'b1; load(5'd6, 32'h7777, 32'h0, 32'hFFFF_FFFF); PC_Atual = 32'h6100;
        #1;
        chk("exit_stall", 32'(Stall), 32'd1);
        switch_to(1, 32'h1010, 1'b1);
        PC_Atual = 32'h1020;
        #1;
        measure(50, n);
        chk("post_exit_q1", 32'(n), 32'd5);
        switch_to(3, 32'h3020, 1'b0);
        PC_Atual = 32'h3030;
        #1;
        measure(50, n);
        chk("post_exit_q3", 32'(n), 32'd5);
        switch_to(1, 32'h1020, 1'b0);

        // No preemption with Enable_Sched=0, nor with Quantum=0.
        Enable_Sched = 1'b0;
        #1;
        measure(1000, n);
        chk("no_preempt_disabled", 32'(n), 32'd1000);
        Quantum = 16'd0; Enable_Sched = 1'b1; PC_Atual = 32'h1030; Yield = 1'b1;
        #1;
        chk("yield2_stall", 32'(Stall), 32'd1);
        switch_to(3, 32'h3030, 1'b0);
        measure(1000, n);
        chk("no_preempt_q0", 32'(n), 32'd1000);

        // Asynchronous reset in the middle of RESTORE.
        Yield = 1'b1;
        cyc();
        Yield = 1'b0;
        cyc();
        chk("pre_reset_pc_load", 32'(PC_Load), 32'd1);
        chk("pre_reset_pid", 32'(PID_CPU), 32'd1);
        chk("pre_reset_pc_novo", PC_Novo, 32'h1030);
        Reset = 1'b1;
        #1;
        chk("async_pc_load", 32'(PC_Load), 32'd0);
        chk("async_stall", 32'(Stall), 32'd1);
        chk("async_pid", 32'(PID_CPU), 32'd0);
        chk("async_pc_novo", PC_Novo, 32'd0);
        chk("async_num_trocas", 32'(Num_Trocas), 32'd0);
        #2;
        Reset = 1'b0;
        cyc(); cyc(); cyc();
        chk("post_reset_idle", 32'(Stall), 32'd1);
        chk("post_reset_no_load", 32'(PC_Load), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
